pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline boundary register for the multi-stage core, generalising the fixed stage registers (e.g. MEM/WB) into one reusable block.
- Carries an opaque payload bus plus a control bus between stages under valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered o_ready, so downstream stall never combinationally reaches upstream.
- Supports synchronous flush (squash) that kills in-flight entries and zeroes their control bits.

Parameters:
PAYLOAD_W, 256, width of data payload (PCs, operands, instruction, memory-interface fields).
CTRL_W, 8, width of control bits (reg_write, mem_to_reg, jump, halt, ...); forced to zero whenever the entry is invalid or flushed.
RESET_PAYLOAD, {PAYLOAD_W{1'b0}}, payload value loaded on reset and on flush.
CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_flush  in  1  synchronous squash of all held entries.
i_valid  in  1  upstream entry valid.
o_ready  out  1  block can accept an entry; registered.
i_data  in  PAYLOAD_W  upstream payload.
i_ctrl  in  CTRL_W  upstream control bits.
o_valid  out  1  downstream entry valid.
i_ready  in  1  downstream accepts.
o_data  out  PAYLOAD_W  head payload.
o_ctrl  out  CTRL_W  head control; all zero when o_valid=0.
o_count  out  2  entries held (0..2).

Behaviour:
- Storage: main register (head, drives outputs) and skid register, each with a valid bit.
- State encoding: EMPTY (count 0), FULL (main only, count 1), SKID (main and skid, count 2).
- Handshakes:
  - accept = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - o_ready = (state != SKID), taken from flops.
- Transitions, with no flush:
  - EMPTY: accept -> FULL; main loads input.
  - FULL, accept & pop: stay FULL; main loads input.
  - FULL, accept & !pop: -> SKID; skid loads input.
  - FULL, !accept & pop: -> EMPTY.
  - FULL, otherwise: hold.
  - SKID, pop: -> FULL; main loads skid (accept is impossible because o_ready=0).
  - SKID, otherwise: hold.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Latency: one cycle from accept in EMPTY to o_valid. Zero-bubble throughput of 1 entry/cycle while i_ready=1.
- Flush:
  - On a clock edge with i_flush=1, the next state is EMPTY.
  - Both valids clear, payloads load RESET_PAYLOAD, ctrl loads 0.
  - Flush beats a simultaneous accept: the incoming entry is dropped.
  - A simultaneous pop still completes downstream in that cycle.
- Reset (async, asserted at any time including mid-transfer): state EMPTY, o_valid=0, o_ready=1, o_count=0, o_data=RESET_PAYLOAD, o_ctrl=0, skid contents cleared.
- Reset deassertion: first accept possible on the first edge after i_rst falls.
- Output qualification:
  - o_ctrl is gated to 0 when o_valid=0.
  - o_data holds its last value when invalid, except after reset or flush.
- Payload and ctrl are never modified by the block, only stored.

Optional Feature:
- Macro: PIPE_STAGE_SKID_PERF_EN.
- Enabled:
  - Adds outputs o_stall_cnt[CNT_W] and o_bubble_cnt[CNT_W], both reset to 0 and saturating at all-ones.
  - o_stall_cnt increments each cycle with o_valid & !i_ready.
  - o_bubble_cnt increments each cycle with !o_valid & i_ready.
  - Neither counter is cleared by flush.
- Disabled: ports and logic absent; the block is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (EMPTY/FULL/SKID);
  - localparam NOP_INSTR = 32'h00000013 for use in stage-specific RESET_PAYLOAD;
  - per-stage ctrl bit index constants.
- One natural sub-module: pipe_entry_reg (one payload+ctrl+valid register with load/clear enables), instantiated twice for main and skid.
- The FSM stays in the top module.

Test Plan:
1. Stream 0x1..0x10 with i_valid=1 and i_ready=1 throughout -> o_data shows 0x1..0x10 on consecutive cycles starting 1 cycle after the first accept; o_ready stays 1; no bubbles.
2. Push A=0xAA, B=0xBB while i_ready=0 -> o_count reaches 2 and o_ready=0; raise i_ready -> outputs A then B on consecutive cycles and o_ready returns to 1.
3. With count=2 and ctrl=0xFF, assert i_flush together with i_valid (data 0xCC) -> next cycle o_valid=0, o_ctrl=0, o_count=0, o_data=RESET_PAYLOAD; 0xCC never appears.
4. Assert i_rst asynchronously mid-cycle while in SKID -> outputs immediately go to o_valid=0, o_ready=1, o_ctrl=0, o_count=0 without waiting for a clock edge.
5. Random valid/ready toggling for 10k cycles against a scoreboard model -> output sequence equals accepted input sequence; no drop or duplicate; o_ctrl=0 whenever o_valid=0.
6. With PIPE_STAGE_SKID_PERF_EN defined, hold a valid entry with i_ready=0 for 5 cycles, then idle with i_ready=1 for 3 cycles -> o_stall_cnt=5, o_bubble_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: FSM states,
// the NOP payload constant and per-stage control bit positions.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int EX_CTRL_ALU_SRC    = 0;
   localparam int EX_CTRL_BRANCH     = 1;
   localparam int EX_CTRL_JUMP       = 2;
   localparam int MEM_CTRL_MEM_READ  = 3;
   localparam int MEM_CTRL_MEM_WRITE = 4;
   localparam int WB_CTRL_REG_WRITE  = 5;
   localparam int WB_CTRL_MEM_TO_REG = 6;
   localparam int WB_CTRL_HALT       = 7;

   function automatic logic [1:0] state_count(state_e s);
      unique case (s)
         EMPTY:   return 2'd0;
         FULL:    return 2'd1;
         SKID:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload, control bits and valid flag.
// Clear has priority over load; drop invalidates but keeps payload.
module pipe_entry_reg #(
   parameter int PAYLOAD_W = 256,
   parameter int CTRL_W    = 8,
   parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_ld,
   input  logic                 i_drop,
   input  logic [PAYLOAD_W-1:0] i_data,
   input  logic [CTRL_W-1:0]    i_ctrl,
   output logic                 o_valid,
   output logic [PAYLOAD_W-1:0] o_data,
   output logic [CTRL_W-1:0]    o_ctrl
);

   logic                 valid_q, valid_d;
   logic [PAYLOAD_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0]    ctrl_q, ctrl_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (i_clr) begin
         valid_d = 1'b0;
         data_d  = RESET_PAYLOAD;
         ctrl_d  = '0;
      end else if (i_ld) begin
         valid_d = 1'b1;
         data_d  = i_data;
         ctrl_d  = i_ctrl;
      end else if (i_drop) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= RESET_PAYLOAD;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Reusable pipeline boundary register with 2-entry skid buffer.
// Define PIPE_STAGE_SKID_PERF_EN to add stall/bubble counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 256,
   parameter int CTRL_W    = 8,
   parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = {PAYLOAD_W{1'b0}},
   parameter int CNT_W     = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [PAYLOAD_W-1:0] i_data,
   input  logic [CTRL_W-1:0]    i_ctrl,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [PAYLOAD_W-1:0] o_data,
   output logic [CTRL_W-1:0]    o_ctrl,
`ifdef PIPE_STAGE_SKID_PERF_EN
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic [CNT_W-1:0]     o_bubble_cnt,
`endif
   output logic [1:0]           o_count
);

   state_e state_q, state_d;

   logic                 m_valid, m_ld, m_drop;
   logic [PAYLOAD_W-1:0] m_data, m_ld_data;
   logic [CTRL_W-1:0]    m_ctrl, m_ld_ctrl;
   logic                 s_valid, s_ld, s_drop;
   logic [PAYLOAD_W-1:0] s_data;
   logic [CTRL_W-1:0]    s_ctrl;
   logic                 accept, pop;

   assign o_ready = (state_q != SKID);
   assign accept  = i_valid & o_ready;
   assign pop     = m_valid & i_ready;

   // skid is valid only in SKID, so it feeds main on the refill pop
   assign m_ld_data = s_valid ? s_data : i_data;
   assign m_ld_ctrl = s_valid ? s_ctrl : i_ctrl;

   always_comb begin
      state_d = state_q;
      m_ld    = 1'b0;
      m_drop  = 1'b0;
      s_ld    = 1'b0;
      s_drop  = 1'b0;
      if (i_flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = FULL;
                  m_ld    = 1'b1;
               end
            end
            FULL: begin
               if (accept && pop) begin
                  m_ld = 1'b1;
               end else if (accept) begin
                  state_d = SKID;
                  s_ld    = 1'b1;
               end else if (pop) begin
                  state_d = EMPTY;
                  m_drop  = 1'b1;
               end
            end
            SKID: begin
               if (pop) begin
                  state_d = FULL;
                  m_ld    = 1'b1;
                  s_drop  = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   pipe_entry_reg #(
      .PAYLOAD_W    (PAYLOAD_W),
      .CTRL_W       (CTRL_W),
      .RESET_PAYLOAD(RESET_PAYLOAD)
   ) u_main (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (i_flush),
      .i_ld   (m_ld),
      .i_drop (m_drop),
      .i_data (m_ld_data),
      .i_ctrl (m_ld_ctrl),
      .o_valid(m_valid),
      .o_data (m_data),
      .o_ctrl (m_ctrl)
   );

   pipe_entry_reg #(
      .PAYLOAD_W    (PAYLOAD_W),
      .CTRL_W       (CTRL_W),
      .RESET_PAYLOAD(RESET_PAYLOAD)
   ) u_skid (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (i_flush),
      .i_ld   (s_ld),
      .i_drop (s_drop),
      .i_data (i_data),
      .i_ctrl (i_ctrl),
      .o_valid(s_valid),
      .o_data (s_data),
      .o_ctrl (s_ctrl)
   );

   assign o_valid = m_valid;
   assign o_data  = m_data;
   assign o_ctrl  = m_valid ? m_ctrl : '0;
   assign o_count = state_count(state_q);

`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (m_valid && !i_ready && stall_q != '1)
         stall_d = stall_q + 1'b1;
      if (!m_valid && i_ready && bubble_q != '1)
         bubble_d = bubble_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign o_stall_cnt  = stall_q;
   assign o_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random bench for pipe_stage_skid with a FIFO scoreboard.
// Counter checks run only when PIPE_STAGE_SKID_PERF_EN is defined.
module tb_pipe_stage_skid;

   localparam int PW = 32;
   localparam int CW = 8;
   localparam int NW = 32;
   localparam logic [PW-1:0] RST_PL = 32'h0000_0013;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          out_ready_o;
   logic [PW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          ds_ready;
   logic [PW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    count;
`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [NW-1:0] stall_cnt;
   logic [NW-1:0] bubble_cnt;
`endif

   int tests;
   int failed;
   logic [PW+CW-1:0] sb[$];

   pipe_stage_skid #(
      .PAYLOAD_W    (PW),
      .CTRL_W       (CW),
      .RESET_PAYLOAD(RST_PL),
      .CNT_W        (NW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_valid     (in_valid),
      .o_ready     (out_ready_o),
      .i_data      (in_data),
      .i_ctrl      (in_ctrl),
      .o_valid     (out_valid),
      .i_ready     (ds_ready),
      .o_data      (out_data),
      .o_ctrl      (out_ctrl),
`ifdef PIPE_STAGE_SKID_PERF_EN
      .o_stall_cnt (stall_cnt),
      .o_bubble_cnt(bubble_cnt),
`endif
      .o_count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      logic [PW+CW-1:0] e;
      #1;
      chk("count", 64'(count), 64'(sb.size()));
      chk("ready", 64'(out_ready_o), 64'(sb.size() < 2));
      if (!out_valid) chk("ctrl_gate", 64'(out_ctrl), 64'd0);
      if (out_valid && ds_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("data", 64'(out_data), 64'(e[PW+CW-1:CW]));
            chk("ctrl", 64'(out_ctrl), 64'(e[CW-1:0]));
         end
      end
      if (flush) sb.delete();
      else if (in_valid && out_ready_o) sb.push_back({in_data, in_ctrl});
      @(negedge clk);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready"}, 64'(out_ready_o), 64'd1);
      chk({tag, "_count"}, 64'(count), 64'd0);
      chk({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      ds_ready = 1'b0;
      in_data  = '0;
      in_ctrl  = '0;
      #1;
      chk_empty("reset");
      chk("reset_data", 64'(out_data), 64'(RST_PL));
      @(negedge clk);
      rst = 1'b0;

      // full-rate stream
      ds_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = PW'(i);
         in_ctrl  = CW'(i);
         if (i > 1) chk("no_bubble", 64'(out_valid), 64'd1);
         cycle();
      end
      in_valid = 1'b0;
      chk("stream_tail", 64'(out_valid), 64'd1);
      cycle();
      cycle();

      // back-pressure fills the skid, then drains in order
      ds_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hAA;
      in_ctrl  = 8'h0A;
      cycle();
      in_data  = 32'hBB;
      in_ctrl  = 8'h0B;
      cycle();
      in_valid = 1'b0;
      chk("skid_count", 64'(count), 64'd2);
      chk("skid_ready", 64'(out_ready_o), 64'd0);
      cycle();
      ds_ready = 1'b1;
      chk("drain_a", 64'(out_data), 64'hAA);
      cycle();
      chk("drain_b", 64'(out_data), 64'hBB);
      cycle();
      chk("drained_ready", 64'(out_ready_o), 64'd1);
      cycle();

      // flush while full of skid entries, with an input offered
      ds_ready = 1'b0;
      in_valid = 1'b1;
      in_ctrl  = 8'hFF;
      in_data  = 32'h11;
      cycle();
      in_data  = 32'h22;
      cycle();
      flush    = 1'b1;
      in_data  = 32'hCC;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk_empty("flush2");
      chk("flush2_data", 64'(out_data), 64'(RST_PL));

      // flush beats an accept in FULL
      in_valid = 1'b1;
      in_data  = 32'h33;
      in_ctrl  = 8'hFF;
      cycle();
      flush    = 1'b1;
      in_data  = 32'hCC;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk_empty("flush1");
      chk("flush1_data", 64'(out_data), 64'(RST_PL));
      ds_ready = 1'b1;
      cycle();
      cycle();

      // asynchronous reset in SKID
      ds_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h44;
      cycle();
      in_data  = 32'h55;
      cycle();
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      chk_empty("async_rst");
      chk("async_rst_data", 64'(out_data), 64'(RST_PL));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;

      // first accept right after reset release, then random traffic
      in_valid = 1'b1;
      in_data  = 32'h66;
      in_ctrl  = 8'h06;
      cycle();
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      for (int n = 0; n < 10000; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         ds_ready = 1'($urandom_range(0, 1));
         flush    = ($urandom_range(0, 63) == 0);
         in_data  = $urandom;
         in_ctrl  = CW'($urandom);
         cycle();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      ds_ready = 1'b1;
      repeat (4) cycle();
      chk("final_count", 64'(count), 64'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
      ds_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("cnt_rst_stall", 64'(stall_cnt), 64'd0);
      chk("cnt_rst_bubble", 64'(bubble_cnt), 64'd0);
      in_valid = 1'b1;
      in_data  = 32'h77;
      in_ctrl  = 8'h07;
      cycle();
      in_valid = 1'b0;
      repeat (5) cycle();
      ds_ready = 1'b1;
      cycle();
      repeat (3) cycle();
      chk("stall_cnt", 64'(stall_cnt), 64'd5);
      chk("bubble_cnt", 64'(bubble_cnt), 64'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
